// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_pkg
//  Purpose  : Shared constants for the sequential multiply-accumulate block:
//             default operand widths and FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package mac_pkg;

  // Default operand widths (A is La bits, B is Lb bits)
  localparam int unsigned c_LA_DEFAULT = 4;
  localparam int unsigned c_LB_DEFAULT = 4;

  // Controller state encoding
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_MUL  = 2'd1;
  localparam logic [1:0] c_ST_ADD  = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/seq_mul_core.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mul_core
//  Purpose  : Radix-2 shift-add multiplier, one bit of B per cycle, LSB
//             first. In signed mode the MSB partial product is subtracted,
//             which gives an exact two's-complement product.
//  Revision : 1.0  initial release
// ============================================================================
module seq_mul_core
  import mac_pkg::*;
#(
  parameter int La = c_LA_DEFAULT,
  parameter int Lb = c_LB_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,   // capture operands, clear partial product
  input  logic             i_run,    // process one multiplier bit this cycle
  input  logic [La-1:0]    i_a,
  input  logic [Lb-1:0]    i_b,
  input  logic             i_sg,
  output logic [La+Lb-1:0] product,
  output logic             done      // last multiplier bit handled this cycle
);

  localparam int LP = La + Lb;
  localparam int CW = $clog2(Lb + 1);
  localparam logic [CW-1:0] c_LAST = CW'(Lb - 1);

  logic [LP-1:0] r_mcand;   // multiplicand, shifted left once per bit
  logic [LP-1:0] r_acc;     // partial product
  logic [Lb-1:0] r_mplr;    // multiplier, shifted right once per bit
  logic [CW-1:0] r_cnt;     // index of the multiplier bit being processed
  logic          r_sg;

  logic [LP-1:0] w_a_ext;
  logic          w_msb;

  // The multiplicand is widened to the full product width up front so each
  // shifted copy already carries its sign.
  assign w_a_ext = {{Lb{i_sg & i_a[La-1]}}, i_a};
  assign w_msb   = (r_cnt == c_LAST);

  // Load operands on accept, then one shift-add step per run cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_sg    <= 1'b0;
    end else if (i_load) begin
      r_mcand <= w_a_ext;
      r_acc   <= '0;
      r_mplr  <= i_b;
      r_cnt   <= '0;
      r_sg    <= i_sg;
    end else if (i_run) begin
      if (r_mplr[0]) begin
        // B's MSB has negative weight in two's complement
        r_acc <= (r_sg && w_msb) ? (r_acc - r_mcand) : (r_acc + r_mcand);
      end
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= w_msb ? '0 : (r_cnt + CW'(1));
    end
  end

  assign product = r_acc;
  assign done    = i_run & w_msb;

endmodule : seq_mul_core
`default_nettype wire

// File: rtl/seq_mac_acc.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mac_acc
//  Purpose  : Sequential multiply-add / multiply-accumulate. Computes
//             Y = C + A*B, or Y = Y + A*B in accumulate mode, signed or
//             unsigned, with a sticky overflow flag for accumulation and
//             valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module seq_mac_acc
  import mac_pkg::*;
#(
  parameter int La = c_LA_DEFAULT,
  parameter int Lb = c_LB_DEFAULT,
  parameter int Lc = La + Lb,
  parameter int Ly = La + Lb + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [La-1:0] A,
  input  logic [Lb-1:0] B,
  input  logic [Lc-1:0] C,
  input  logic          sg,
  input  logic          acc_en,
  input  logic          acc_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Ly-1:0] Y,
  output logic          ovf
);

  localparam int LP = La + Lb;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [Lc-1:0] r_c;
  logic          r_sg;
  logic          r_acc_en;
  logic [Ly-1:0] r_y;       // accumulator, also the visible result
  logic          r_ovf;

  logic          w_idle;
  logic          w_accept;
  logic          w_clr;
  logic          w_run;
  logic          w_mul_done;
  logic [LP-1:0] w_product;
  logic [Ly-1:0] w_p_ext;
  logic [Ly-1:0] w_c_ext;
  logic [Ly-1:0] w_addend;
  logic [Ly:0]   w_sum;
  logic          w_ovf_now;

  assign w_idle   = (r_state == c_ST_IDLE);
  assign w_accept = w_idle & in_valid;
  assign w_clr    = w_idle & acc_clr;
  assign w_run    = (r_state == c_ST_MUL);

  seq_mul_core #(
    .La (La),
    .Lb (Lb)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_run   (w_run),
    .i_a     (A),
    .i_b     (B),
    .i_sg    (sg),
    .product (w_product),
    .done    (w_mul_done)
  );

  // Widen product and addend to the result width according to signedness;
  // the extra top bit of w_sum is the unsigned carry out.
  assign w_p_ext   = {{(Ly-LP){r_sg & w_product[LP-1]}}, w_product};
  assign w_c_ext   = {{(Ly-Lc){r_sg & r_c[Lc-1]}}, r_c};
  assign w_addend  = r_acc_en ? r_y : w_c_ext;
  assign w_sum     = {1'b0, w_addend} + {1'b0, w_p_ext};
  assign w_ovf_now = r_acc_en &
                     (r_sg ? ((w_addend[Ly-1] == w_p_ext[Ly-1]) &&
                              (w_sum[Ly-1]    != w_addend[Ly-1]))
                           : w_sum[Ly]);

  // Next-state decode: IDLE -> MUL (Lb cycles) -> ADD -> DONE -> IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (in_valid)   w_state_nxt = c_ST_MUL;
      c_ST_MUL:  if (w_mul_done) w_state_nxt = c_ST_ADD;
      c_ST_ADD:                  w_state_nxt = c_ST_DONE;
      c_ST_DONE: if (out_ready)  w_state_nxt = c_ST_IDLE;
      default:                   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture the non-multiplier operands on accept; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c      <= '0;
      r_sg     <= 1'b0;
      r_acc_en <= 1'b0;
    end else if (w_accept) begin
      r_c      <= C;
      r_sg     <= sg;
      r_acc_en <= acc_en;
    end
  end

  // Accumulator and sticky overflow; a clear in IDLE takes effect before an
  // operation accepted in the same cycle reaches ADD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y   <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == c_ST_ADD) begin
      r_y <= w_sum[Ly-1:0];
      if (w_ovf_now) r_ovf <= 1'b1;
    end else if (w_clr) begin
      r_y   <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign in_ready  = w_idle;
  assign out_valid = (r_state == c_ST_DONE);
  assign Y         = r_y;
  assign ovf       = r_ovf;

endmodule : seq_mac_acc
`default_nettype wire
